// File: rtl/rf_writeback_arbiter_if.sv
// Writeback/issue bundle between the execute/memory/decode stages and the
// register file writeback arbiter.
interface rf_writeback_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
  logic                      issue_valid_i;
  logic [REG_ADDR_WIDTH-1:0] issue_rd_i;
  logic                      issue_ready_o;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i;
  logic                      rs1_busy_o;
  logic                      rs2_busy_o;
  logic                      req0_valid_i;
  logic [REG_ADDR_WIDTH-1:0] req0_addr_i;
  logic [XLEN-1:0]           req0_data_i;
  logic                      req0_ready_o;
  logic                      req1_valid_i;
  logic [REG_ADDR_WIDTH-1:0] req1_addr_i;
  logic [XLEN-1:0]           req1_data_i;
  logic                      req1_ready_o;
  logic                      rf_write_enable_o;
  logic [REG_ADDR_WIDTH-1:0] rf_write_address_o;
  logic [XLEN-1:0]           rf_write_data_o;

  modport master (
    output issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    output req0_valid_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  issue_ready_o, rs1_busy_o, rs2_busy_o, req0_ready_o, req1_ready_o,
    input  rf_write_enable_o, rf_write_address_o, rf_write_data_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    input  req0_valid_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output issue_ready_o, rs1_busy_o, rs2_busy_o, req0_ready_o, req1_ready_o,
    output rf_write_enable_o, rf_write_address_o, rf_write_data_o
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU = req0,
// load unit = req1) with a per-register pending-write scoreboard for decode.
module rf_writeback_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic                  clk_i,
    input logic                  rst_i,
    rf_writeback_arbiter_if.slave wb
);
  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [NUM_REGS-1:0]       pending_reg;
  logic [NUM_REGS-1:0]       pending_next;
  logic                      ptr_reg;
  logic                      wr_en_reg;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [XLEN-1:0]           wr_data_reg;

  logic                      grant0;
  logic                      grant1;
  logic                      xfer;
  logic                      issue_accept;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [XLEN-1:0]           sel_data;

  // Pointer only matters under contention; a lone requester always wins.
  assign grant0 = ~rst_i & wb.req0_valid_i & (~wb.req1_valid_i | ~ptr_reg);
  assign grant1 = ~rst_i & wb.req1_valid_i & (~wb.req0_valid_i |  ptr_reg);
  assign xfer   = grant0 | grant1;

  assign sel_addr = grant1 ? wb.req1_addr_i : wb.req0_addr_i;
  assign sel_data = grant1 ? wb.req1_data_i : wb.req0_data_i;

  assign wb.req0_ready_o = grant0;
  assign wb.req1_ready_o = grant1;

  assign wb.issue_ready_o = ~rst_i & ~pending_reg[wb.issue_rd_i];
  assign issue_accept     = wb.issue_valid_i & wb.issue_ready_o;

  assign wb.rs1_busy_o = pending_reg[wb.rs1_addr_i];
  assign wb.rs2_busy_o = pending_reg[wb.rs2_addr_i];

  assign wb.rf_write_enable_o  = wr_en_reg;
  assign wb.rf_write_address_o = wr_addr_reg;
  assign wb.rf_write_data_o    = wr_data_reg;

  // A new issue to a register beats the retiring write to that register.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        assign pending_next[gi] =
            (issue_accept && wb.issue_rd_i == REG_ADDR_WIDTH'(gi)) ||
            (pending_reg[gi] && !(wr_en_reg && wr_addr_reg == REG_ADDR_WIDTH'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg <= '0;
      ptr_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      wr_en_reg   <= xfer && (sel_addr != '0);
      if (xfer) begin
        ptr_reg     <= grant0;
        wr_addr_reg <= sel_addr;
        wr_data_reg <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed plus randomized check of rf_writeback_arbiter against a
// cycle-level reference model of the arbitration and scoreboard rules.
`timescale 1ns/1ps
module tb_rf_writeback_arbiter;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  rf_writeback_arbiter_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();

  rf_writeback_arbiter #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Behavioural register file fed by the write port.
  logic [31:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
  always @(negedge clk)
    if (bus.rf_write_enable_o) rf_mem[bus.rf_write_address_o] <= bus.rf_write_data_o;

  // Reference model state.
  bit          m_pend [32];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_next_req;   // requester that wins the next contended cycle
  bit          g0, g1;       // grants seen in the last step

  task automatic reset_model();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_en = 0; m_addr = '0; m_data = '0; m_next_req = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    bit w0, w1, ir;
    @(negedge clk);
    if (rst) begin
      w0 = 0; w1 = 0;
    end else if (bus.req0_valid_i && bus.req1_valid_i) begin
      w0 = (m_next_req == 0); w1 = (m_next_req == 1);
    end else begin
      w0 = bus.req0_valid_i; w1 = bus.req1_valid_i;
    end
    ir = !rst && !m_pend[bus.issue_rd_i];
    chk({tag, ".ready0"},      32'(bus.req0_ready_o),       32'(w0));
    chk({tag, ".ready1"},      32'(bus.req1_ready_o),       32'(w1));
    chk({tag, ".issue_ready"}, 32'(bus.issue_ready_o),      32'(ir));
    chk({tag, ".rs1_busy"},    32'(bus.rs1_busy_o),         32'(m_pend[bus.rs1_addr_i]));
    chk({tag, ".rs2_busy"},    32'(bus.rs2_busy_o),         32'(m_pend[bus.rs2_addr_i]));
    chk({tag, ".wr_en"},       32'(bus.rf_write_enable_o),  32'(m_en));
    chk({tag, ".wr_addr"},     32'(bus.rf_write_address_o), 32'(m_addr));
    chk({tag, ".wr_data"},     bus.rf_write_data_o,         m_data);
    @(posedge clk);
    if (rst) begin
      reset_model();
    end else begin
      if (m_en) m_pend[m_addr] = 0;
      if (bus.issue_valid_i && ir && bus.issue_rd_i != 0) m_pend[bus.issue_rd_i] = 1;
      if (w0 || w1) begin
        m_addr     = w1 ? bus.req1_addr_i : bus.req0_addr_i;
        m_data     = w1 ? bus.req1_data_i : bus.req0_data_i;
        m_en       = (m_addr != 0);
        m_next_req = w0 ? 1 : 0;
      end else begin
        m_en = 0;
      end
    end
    g0 = w0; g1 = w1;
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i = 0; bus.issue_rd_i = '0;
    bus.req0_valid_i  = 0; bus.req1_valid_i = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd3; bus.req0_data_i = 32'h11;
    bus.req1_valid_i = 1; bus.req1_addr_i = 5'd4; bus.req1_data_i = 32'h22;
    @(posedge clk); #1;
    reset_model();
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr_i = 5'(a);
      #1;
      chk("reset.rs1_busy", 32'(bus.rs1_busy_o), 32'd0);
    end
    step("reset0");
    step("reset1");

    // Single write from the ALU path.
    rst = 0; idle_inputs();
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd5; bus.req0_data_i = 32'hDEADBEEF;
    step("single.hs");
    bus.req0_valid_i = 0;
    step("single.wr");
    step("single.idle");

    // Fresh pointer, then four cycles of contention.
    rst = 1; step("rst_ptr");
    rst = 0;
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd3; bus.req0_data_i = 32'hA3;
    bus.req1_valid_i = 1; bus.req1_addr_i = 5'd4; bus.req1_data_i = 32'hB4;
    for (int i = 0; i < 4; i++) step("contend");
    idle_inputs();
    step("contend.tail0");
    step("contend.tail1");

    // Scoreboard: issue rd 7, load unit retires it.
    bus.issue_valid_i = 1; bus.issue_rd_i = 5'd7;
    step("sb.issue7");
    bus.rs1_addr_i = 5'd7;
    step("sb.busy7");
    bus.issue_valid_i = 0;
    bus.req1_valid_i = 1; bus.req1_addr_i = 5'd7; bus.req1_data_i = 32'h55;
    step("sb.wb7");
    bus.req1_valid_i = 0;
    step("sb.wb7_n1");
    step("sb.wb7_n2");
    chk("sb.rf7", rf_mem[7], 32'h55);

    // Re-issue of a still-pending rd 9 during its write is refused; bit clears.
    bus.issue_valid_i = 1; bus.issue_rd_i = 5'd9; bus.rs1_addr_i = 5'd9;
    step("sc9.issue");
    bus.issue_valid_i = 0;
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd9; bus.req0_data_i = 32'h99;
    step("sc9.hs");
    bus.req0_valid_i = 0; bus.issue_valid_i = 1;
    step("sc9.wr");
    bus.issue_valid_i = 0;
    step("sc9.after");

    // Non-pending rd 10 written while a new issue lands: the set wins.
    bus.rs1_addr_i = 5'd10; bus.rs2_addr_i = 5'd10;
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd10; bus.req0_data_i = 32'hAA;
    step("sc10.hs");
    bus.req0_valid_i = 0;
    bus.issue_valid_i = 1; bus.issue_rd_i = 5'd10;
    step("sc10.wr_issue");
    bus.issue_valid_i = 0;
    step("sc10.after");
    chk("sc10.busy_kept", 32'(bus.rs1_busy_o), 32'd1);

    // x0 writes and issues.
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd0; bus.req0_data_i = 32'h1234;
    step("x0.hs");
    bus.req0_valid_i = 0;
    bus.issue_valid_i = 1; bus.issue_rd_i = 5'd0; bus.rs1_addr_i = 5'd0;
    step("x0.issue");
    bus.issue_valid_i = 0;
    step("x0.after");

    // Reset right after a handshake.
    bus.issue_valid_i = 1; bus.issue_rd_i = 5'd12; bus.rs2_addr_i = 5'd12;
    step("rstmid.issue");
    bus.issue_valid_i = 0;
    bus.req0_valid_i = 1; bus.req0_addr_i = 5'd12; bus.req0_data_i = 32'hC12;
    step("rstmid.hs");
    bus.req0_valid_i = 0; rst = 1;
    step("rstmid.rst");
    rst = 0;
    step("rstmid.after");
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr_i = 5'(a);
      #1;
      chk("rstmid.busy", 32'(bus.rs1_busy_o), 32'd0);
    end

    // Randomized traffic; requesters hold their request until granted.
    for (int c = 0; c < 400; c++) begin
      if (!bus.req0_valid_i || g0) begin
        bus.req0_valid_i = ($urandom_range(0, 2) != 0);
        bus.req0_addr_i  = 5'($urandom_range(0, 31));
        bus.req0_data_i  = $urandom;
      end
      if (!bus.req1_valid_i || g1) begin
        bus.req1_valid_i = ($urandom_range(0, 2) != 0);
        bus.req1_addr_i  = 5'($urandom_range(0, 31));
        bus.req1_data_i  = $urandom;
      end
      bus.issue_valid_i = ($urandom_range(0, 1) != 0);
      bus.issue_rd_i    = 5'($urandom_range(0, 31));
      bus.rs1_addr_i    = 5'($urandom_range(0, 31));
      bus.rs2_addr_i    = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
